// File: rtl/debug_wb_pkg.sv
// Shared types and constants for the debug Wishbone master: FSM encoding,
// timeout default and the saturating cycle-counter helper.
package debug_wb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StResp = 2'd3
    } state_e;

    localparam int unsigned TimeoutDefault = 255;
    localparam int unsigned CntW           = 16;

    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/debug_master_wb_if.sv
// Command/response handshake plus Wishbone pipelined master bus, bundled so
// the debug master and its environment share a single port.
interface debug_master_wb_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        rsp_timeout;

    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stall_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic [31:0] wb_dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        output cmd_ready,
        output rsp_valid, rsp_dat, rsp_err, rsp_timeout,
        input  rsp_ready,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_stall_i, wb_ack_i, wb_err_i, wb_dat_i
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        input  cmd_ready,
        input  rsp_valid, rsp_dat, rsp_err, rsp_timeout,
        output rsp_ready,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_stall_i, wb_ack_i, wb_err_i, wb_dat_i
    );

endinterface

// File: rtl/debug_master_wb.sv
// Single-outstanding debug bus master: turns one command into one Wishbone
// pipelined transfer and returns data, bus error or timeout as a response.
module debug_master_wb
    import debug_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TimeoutDefault
) (
    input logic               wb_clk_i,
    input logic               wb_rst_ni,
    debug_master_wb_if.master bus
);

    localparam logic [CntW:0] TimeoutLim = (CntW + 1)'(TIMEOUT_CYCLES);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic [3:0]      sel_q, sel_d;
    logic [31:0]     rdat_q, rdat_d;
    logic            err_q, err_d;
    logic            to_q, to_d;

    logic sample, got_ack, got_err, expire;

    // Ack/err only count once the request has been accepted (no stall).
    assign sample  = (state_q == StWait) || ((state_q == StReq) && !bus.wb_stall_i);
    assign got_ack = sample && bus.wb_ack_i;
    assign got_err = sample && bus.wb_err_i;
    // True on the cycle that completes TIMEOUT_CYCLES spent in REQ+WAIT.
    assign expire  = ({1'b0, cnt_q} + 1'b1) >= TimeoutLim;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        rdat_d  = rdat_q;
        err_d   = err_q;
        to_d    = to_q;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    we_d    = bus.cmd_we;
                    adr_d   = bus.cmd_adr;
                    dat_d   = bus.cmd_dat;
                    sel_d   = bus.cmd_sel;
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq, StWait: begin
                cnt_d = sat_inc(cnt_q);
                if (got_err) begin
                    rdat_d  = '0;
                    err_d   = 1'b1;
                    to_d    = 1'b0;
                    state_d = StResp;
                end else if (got_ack) begin
                    rdat_d  = we_q ? 32'h0 : bus.wb_dat_i;
                    err_d   = 1'b0;
                    to_d    = 1'b0;
                    state_d = StResp;
                end else if (expire) begin
                    rdat_d  = '0;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    state_d = StResp;
                end else if ((state_q == StReq) && !bus.wb_stall_i) begin
                    state_d = StWait;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    assign bus.cmd_ready   = (state_q == StIdle) && wb_rst_ni;
    assign bus.rsp_valid   = (state_q == StResp);
    assign bus.rsp_dat     = rdat_q;
    assign bus.rsp_err     = err_q;
    assign bus.rsp_timeout = to_q;
    assign bus.wb_cyc_o    = (state_q == StReq) || (state_q == StWait);
    assign bus.wb_stb_o    = (state_q == StReq);
    assign bus.wb_we_o     = we_q;
    assign bus.wb_adr_o    = adr_q;
    assign bus.wb_dat_o    = dat_q;
    assign bus.wb_sel_o    = sel_q;

endmodule

// File: tb/tb_debug_master_wb.sv
// Bench for debug_master_wb: directed vector table, reset-in-flight sequence
// and random transfers checked against a cycle-count reference model.
module tb_debug_master_wb;

    localparam int TO    = 8;
    localparam int KAck  = 0;
    localparam int KErr  = 1;
    localparam int KBoth = 2;
    localparam int KNone = 3;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          s;      // stalled cycles before accept
        int          d;      // cycles after accept cycle until slave responds
        int          kind;
        logic [31:0] rdata;
        int          hold;   // cycles rsp_ready is held low
        int          e_stb;
        int          e_cyc;
        logic [31:0] e_dat;
        logic        e_err;
        logic        e_to;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    debug_master_wb_if bus ();

    debug_master_wb #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: the slave answers at cycle s+d after REQ entry; anything at or
    // past TO cycles is a timeout, and stb lasts until accept or abort.
    function automatic vec_t predict(input vec_t v);
        vec_t r;
        int   k;
        r = v;
        k = v.s + v.d;
        if (v.kind != KNone && k < TO) begin
            r.e_cyc = k + 1;
            r.e_err = (v.kind != KAck);
            r.e_to  = 1'b0;
            r.e_dat = (v.kind == KAck && !v.we) ? v.rdata : 32'h0;
        end else begin
            r.e_cyc = TO;
            r.e_err = 1'b1;
            r.e_to  = 1'b1;
            r.e_dat = 32'h0;
        end
        r.e_stb = (v.s + 1 < r.e_cyc) ? v.s + 1 : r.e_cyc;
        return r;
    endfunction

    function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                input int s, input int d, input int kind,
                                input logic [31:0] rdata, input int hold, input int e_stb,
                                input int e_cyc, input logic [31:0] e_dat, input logic e_err,
                                input logic e_to);
        vec_t v;
        v.we = we; v.adr = adr; v.dat = dat; v.sel = 4'hF;
        v.s = s; v.d = d; v.kind = kind; v.rdata = rdata; v.hold = hold;
        v.e_stb = e_stb; v.e_cyc = e_cyc; v.e_dat = e_dat; v.e_err = e_err; v.e_to = e_to;
        return v;
    endfunction

    task automatic idle_slave();
        bus.wb_stall_i = 1'b0;
        bus.wb_ack_i   = 1'b0;
        bus.wb_err_i   = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int   ncyc;
        int   nstb;
        logic stable;
        logic hit;
        @(negedge clk);
        check({tag, ".cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = v.we;
        bus.cmd_adr   = v.adr;
        bus.cmd_dat   = v.dat;
        bus.cmd_sel   = v.sel;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_adr   = $urandom();
        bus.cmd_dat   = $urandom();
        ncyc   = 0;
        nstb   = 0;
        stable = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (!bus.wb_cyc_o) break;
            ncyc++;
            if (bus.wb_stb_o) nstb++;
            if (bus.wb_adr_o !== v.adr || bus.wb_dat_o !== v.dat || bus.wb_sel_o !== v.sel ||
                bus.wb_we_o !== v.we) stable = 1'b0;
            hit = (k == v.s + v.d) && (v.kind != KNone);
            bus.wb_stall_i = (k < v.s);
            bus.wb_ack_i   = ((k < v.s) && $urandom_range(0, 1) == 1) ||
                             (hit && (v.kind == KAck || v.kind == KBoth));
            bus.wb_err_i   = hit && (v.kind == KErr || v.kind == KBoth);
            bus.wb_dat_i   = hit ? v.rdata : $urandom();
            @(negedge clk);
        end
        idle_slave();
        check({tag, ".cyc_cycles"}, 32'(ncyc), 32'(v.e_cyc));
        check({tag, ".stb_cycles"}, 32'(nstb), 32'(v.e_stb));
        check({tag, ".bus_stable"}, 32'(stable), 32'd1);
        check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, ".rsp_dat"}, bus.rsp_dat, v.e_dat);
        check({tag, ".rsp_err_to"}, {30'd0, bus.rsp_err, bus.rsp_timeout}, {30'd0, v.e_err, v.e_to});
        for (int h = 0; h < v.hold; h++) begin
            bus.wb_ack_i = $urandom_range(0, 1) == 1;
            bus.wb_err_i = $urandom_range(0, 1) == 1;
            bus.wb_dat_i = $urandom();
            @(negedge clk);
            check({tag, ".hold_flags"},
                  {28'd0, bus.rsp_valid, bus.cmd_ready, bus.rsp_err, bus.rsp_timeout},
                  {28'd0, 1'b1, 1'b0, v.e_err, v.e_to});
            check({tag, ".hold_dat"}, bus.rsp_dat, v.e_dat);
        end
        idle_slave();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, ".release"}, {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'b01);
    endtask

    vec_t tbl[10];
    vec_t v;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = '0;
        bus.cmd_dat   = '0;
        bus.cmd_sel   = '0;
        bus.rsp_ready = 1'b0;
        bus.wb_dat_i  = '0;
        idle_slave();

        //  we    adr            dat          s   d  kind   rdata        hold stb cyc dat          err to
        tbl[0] = mk(1'b1, 32'h1000_0000, 32'h41,       0,  1, KAck,  32'h5555_AAAA, 5, 1, 2, 32'h0,        0, 0);
        tbl[1] = mk(1'b0, 32'h2000_0040, 32'h0,        3,  2, KAck,  32'hDEAD_BEEF, 0, 4, 6, 32'hDEAD_BEEF, 0, 0);
        tbl[2] = mk(1'b0, 32'h3000_0000, 32'h0,        0,  1, KBoth, 32'h1234_5678, 1, 1, 2, 32'h0,        1, 0);
        tbl[3] = mk(1'b0, 32'h4000_0000, 32'h0,        0,  0, KNone, 32'h0,         3, 1, 8, 32'h0,        1, 1);
        tbl[4] = mk(1'b1, 32'h5000_0000, 32'h99,      20,  0, KAck,  32'h0,         0, 8, 8, 32'h0,        1, 1);
        tbl[5] = mk(1'b0, 32'h6000_0004, 32'h0,        0,  0, KAck,  32'hCAFE_F00D, 0, 1, 1, 32'hCAFE_F00D, 0, 0);
        tbl[6] = mk(1'b0, 32'h7000_0008, 32'h0,        2,  5, KAck,  32'h0BAD_CAFE, 0, 3, 8, 32'h0BAD_CAFE, 0, 0);
        tbl[7] = mk(1'b0, 32'h8000_000C, 32'h0,        2,  6, KAck,  32'h0BAD_CAFE, 0, 3, 8, 32'h0,        1, 1);
        tbl[8] = mk(1'b1, 32'h9000_0010, 32'h77,       1,  0, KErr,  32'hFFFF_FFFF, 2, 2, 2, 32'h0,        1, 0);
        tbl[9] = mk(1'b0, 32'hA000_0000, 32'h0,        1,  0, KAck,  32'h0000_0001, 0, 2, 2, 32'h0000_0001, 0, 0);

        repeat (2) @(negedge clk);
        check("reset.outputs",
              {25'd0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.wb_cyc_o,
               bus.wb_stb_o, bus.wb_we_o}, 32'd0);
        check("reset.bus", bus.wb_adr_o | bus.wb_dat_o | {28'd0, bus.wb_sel_o} | bus.rsp_dat, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset.cmd_ready_after", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Reset pulse while waiting for ack: transfer is dropped, no response.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = 32'hB000_0000;
        bus.cmd_sel   = 4'hF;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("rstmid.wait_state", {30'd0, bus.wb_cyc_o, bus.wb_stb_o}, 32'b10);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid.immediate",
              {28'd0, bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid, bus.cmd_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.wb_ack_i = 1'b1;
            @(negedge clk);
            check("rstmid.no_rsp", {29'd0, bus.rsp_valid, bus.wb_cyc_o, bus.cmd_ready}, 32'b001);
        end
        idle_slave();
        run_txn(tbl[0], "post_reset");

        for (int i = 0; i < 40; i++) begin
            v.we    = $urandom_range(0, 1) == 1;
            v.adr   = $urandom();
            v.dat   = $urandom();
            v.sel   = 4'($urandom_range(0, 15));
            v.s     = ($urandom_range(0, 7) == 0) ? 9 : int'($urandom_range(0, 4));
            v.d     = $urandom_range(0, 4);
            v.kind  = $urandom_range(0, 3);
            v.rdata = $urandom();
            v.hold  = $urandom_range(0, 3);
            v = predict(v);
            run_txn(v, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debug_master_wb.md
DEBUG_MASTER_WB -- requirements
Module: debug_master_wb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the bus cycles a transfer may wait for ack/err before abort (range 1..65535).
REQ-002 SHALL have port wb_clk_i  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port wb_rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports cmd_valid input 1, cmd_ready output 1: command handshake, transfer on cycle where both are high.
REQ-005 SHALL have ports cmd_we input 1, cmd_adr input 32, cmd_dat input 32, cmd_sel input 4: write flag, byte address, write data, byte lanes.
REQ-006 SHALL have ports rsp_valid output 1, rsp_ready input 1: response handshake.
REQ-007 SHALL have ports rsp_dat output 32, rsp_err output 1, rsp_timeout output 1: read data, bus error, timeout abort.
REQ-008 SHALL have Wishbone pipelined master ports wb_cyc_o, wb_stb_o, wb_we_o (output 1), wb_adr_o, wb_dat_o (output 32), wb_sel_o (output 4), wb_stall_i, wb_ack_i, wb_err_i (input 1), wb_dat_i (input 32).

Function
REQ-009 SHALL implement FSM IDLE -> REQ -> WAIT -> RESP -> IDLE, one transfer outstanding at a time.
REQ-010 SHALL drive cmd_ready=1 only in IDLE; command accepted in IDLE moves to REQ next cycle, latching we/adr/dat/sel onto wb_*_o.
REQ-011 SHALL assert wb_cyc_o and wb_stb_o throughout REQ; leave REQ when wb_stall_i=0 (request accepted).
REQ-012 SHALL go REQ -> WAIT with wb_stb_o=0, wb_cyc_o=1 when accepted without ack/err that cycle.
REQ-013 SHALL sample wb_ack_i/wb_err_i in WAIT and in REQ on the accept cycle (stall=0); ack/err while stalled SHALL be ignored.
REQ-014 SHALL on ack or err: deassert wb_cyc_o/wb_stb_o next cycle, enter RESP, set rsp_valid=1.
REQ-015 SHALL capture rsp_dat=wb_dat_i on read ack; rsp_dat=0 on write ack, err or timeout.
REQ-016 SHALL give err priority when ack and err coincide: rsp_err=1, rsp_dat=0.
REQ-017 SHALL count cycles spent in REQ+WAIT (16-bit, saturating); on reaching TIMEOUT_CYCLES without ack/err, drop cyc/stb next cycle, enter RESP with rsp_err=1, rsp_timeout=1.
REQ-018 SHALL hold rsp_valid/rsp_dat/rsp_err/rsp_timeout stable in RESP until rsp_ready=1, then return to IDLE next cycle; cmd_ready rises that cycle.
REQ-019 SHALL give minimum latency cmd accept (cycle 0) -> stb (cycle 1) -> ack (cycle 2) -> rsp_valid (cycle 3).
REQ-020 SHALL keep wb_adr_o/wb_dat_o/wb_sel_o/wb_we_o stable from REQ entry until cyc drops.
REQ-021 SHALL ignore wb_ack_i/wb_err_i in IDLE and RESP.

Reset
REQ-022 SHALL on wb_rst_ni=0 immediately force IDLE, counter 0, and outputs: cmd_ready=0 during reset then 1, rsp_valid=0, rsp_dat=0, rsp_err=0, rsp_timeout=0, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0, wb_sel_o=0.
REQ-023 SHALL abandon any in-flight transfer on reset mid-operation with no response issued.

Structure
REQ-024 SHALL place FSM state encoding and TIMEOUT default constant in shared package debug_wb_pkg.
REQ-025 SHALL be a single module; no sub-module required.

Verification
REQ-026 Write: cmd we=1 adr=0x1000_0000 dat=0x41 sel=0xF, slave acks 1 cycle after stb -> wb_dat_o=0x41 one stb cycle, rsp_valid cycle 3, rsp_err=0, rsp_dat=0.
REQ-027 Read with stall: stall=1 for 3 cycles, ack 2 cycles later with wb_dat_i=0xDEAD_BEEF -> stb held 4 cycles, addr stable, rsp_dat=0xDEAD_BEEF.
REQ-028 Error: ack=1 and err=1 same cycle -> rsp_err=1, rsp_timeout=0, rsp_dat=0.
REQ-029 Timeout: TIMEOUT_CYCLES=8, slave silent -> cyc drops after 8 cycles in REQ+WAIT, rsp_err=1, rsp_timeout=1; late ack ignored.
REQ-030 Backpressure/reset: rsp_ready=0 for 5 cycles holds response and cmd_ready=0; wb_rst_ni pulsed low in WAIT -> cyc/stb=0 immediately, no rsp_valid, next command completes normally.
